sdramc_arb2: RTL and testbench
==============================

Name: sdramc_arb2

Overview:
- Two-port round-robin arbiter in front of the SDRAM controller command/data interface.
- Lets two masters (e.g. video fetch and CPU/DMA) share one controller. Each master uses the same cmd/cmd_en/cmd_ack/cmd_len/addr/wr_data/wr_mask/rd_data/rd_data_valid protocol the controller exposes.
- Sequences write-data beats from the granted master to the controller.
- Routes returning read beats to the master that issued the read, using an in-order tag FIFO, so reads may be pipelined.

Parameters:
- AW, 23, byte-address width.
- DW, 32, data width.
- RQ_DEPTH, 4, maximum outstanding reads (tag FIFO depth, power of 2).

Ports:
- clk  in  1  controller clock (166 MHz). One clock; reset is asynchronous and active-high.
- rst  in  1  asynchronous active-high reset.
- pN_cmd  in  1  port N (N=0,1) command: 0 = read, 1 = write.
- pN_cmd_en  in  1  port N request; held until pN_cmd_ack.
- pN_cmd_ack  out  1  port N command accepted.
- pN_cmd_len  in  4  port N burst length minus 1 (beats = len+1).
- pN_addr  in  AW  port N byte address.
- pN_wr_data  in  DW  port N write data.
- pN_wr_mask  in  DW/8  port N byte mask.
- pN_rd_data  out  DW  port N read data (broadcast copy of m_rd_data).
- pN_rd_data_valid  out  1  port N read beat valid.
- m_cmd  out  1  controller command.
- m_cmd_en  out  1  controller request.
- m_cmd_ack  in  1  controller accept.
- m_cmd_len  out  4  controller burst length.
- m_addr  out  AW  controller address.
- m_wr_data  out  DW  controller write data.
- m_wr_mask  out  DW/8  controller byte mask.
- m_rd_data  in  DW  controller read data.
- m_rd_data_valid  in  1  controller read beat valid.
- rd_orphan  out  1  sticky error flag: read beat arrived with no outstanding read.

Behaviour:
- Reset values:
  - state=IDLE, gnt=0, rr_last=1 (port 0 has priority first).
  - Tag FIFO empty, beat counters 0.
  - All pN_cmd_ack, pN_rd_data_valid, m_cmd_en and rd_orphan are 0.
  - m_cmd/m_cmd_len/m_addr/m_wr_data/m_wr_mask follow the gnt mux (port 0 after reset).
- Reset mid-burst aborts everything; no beats are forwarded after reset asserts.
- State machine (registered):
  - IDLE:
    - A port is eligible when pN_cmd_en=1 and (pN_cmd=1 or FIFO not full).
    - If both ports are eligible, gnt = the port other than rr_last.
    - If one is eligible, gnt = that port.
    - Go to REQ on the next edge. IDLE→REQ costs one cycle of latency.
  - REQ:
    - m_cmd_en = pG_cmd_en; m_cmd/len/addr/wr_data/wr_mask are combinationally muxed from port gnt.
    - pG_cmd_ack = m_cmd_ack combinationally; the other port's ack = 0.
    - If pG_cmd_en drops without an ack (protocol violation), return to IDLE.
    - On m_cmd_ack with a write: the ack cycle carries beat 0. If len=0, go to IDLE; else set wcnt=len and go to WDATA.
    - On m_cmd_ack with a read: push {gnt,len} into the tag FIFO and go to IDLE.
    - On any ack, set rr_last=gnt.
  - WDATA:
    - m_wr_data/m_wr_mask are muxed from port gnt, one beat per clock, no stalls.
    - wcnt decrements each clock. Go to IDLE on the edge where wcnt=1.
    - m_cmd_en=0 in this state; no new grant until the burst completes.
- Read return path:
  - m_rd_data is broadcast to both pN_rd_data.
  - pN_rd_data_valid = m_rd_data_valid & FIFO non-empty & (head.port==N), combinational.
  - rcnt counts beats. On the beat where rcnt==head.len: pop, rcnt=0.
  - Beats may be non-consecutive.
  - Push and pop in the same cycle are allowed; occupancy is unchanged.
  - A full FIFO blocks read grants only; writes still proceed.
  - m_rd_data_valid with the FIFO empty: beat dropped, rd_orphan set to 1 until reset.
- Arithmetic: wcnt and rcnt are 4 bits. FIFO pointers are log2(RQ_DEPTH)+1 bits and wrap.

Test Plan:
- Single port-0 write, addr 0x000100, len 3, data 0xA0..0xA3:
  - m_cmd_en asserts the cycle after p0_cmd_en.
  - m_cmd_ack delivers 0xA0; 0xA1..0xA3 follow on 3 consecutive clocks.
  - FSM is back in IDLE after 3 clocks.
- Port 0 and port 1 both request writes continuously:
  - Grants alternate 0,1,0,1.
  - No m_wr_data beat is taken from the non-granted port.
- p0 read (len 1, addr 0x10) then p1 read (len 0, addr 0x20); controller returns 3 beats with a 2-cycle gap:
  - Beats 1-2 raise p0_rd_data_valid only; beat 3 raises p1_rd_data_valid only.
  - FIFO ends empty.
- Issue 4 reads without returning data:
  - A 5th read request is not granted (m_cmd_en stays 0).
  - A simultaneous write from the other port is granted.
  - After one full read burst returns, the 5th read is granted.
- Pulse m_rd_data_valid with the FIFO empty:
  - No pN_rd_data_valid asserts; rd_orphan=1 and stays set until rst.
- Assert rst during WDATA with wcnt=2:
  - All outputs return to reset values asynchronously; no further beats forwarded.
  - After release, a new request is granted to port 0 first.

Source files
------------

// File: rtl/sdramc_arb2.sv
// Two-port round-robin arbiter in front of the SDRAM controller command/data interface.
//
// Two masters share one controller. The granted master's command, address, write data and
// byte mask are muxed onto the m_* side; write bursts are sequenced beat by beat after the
// accepting cycle. Returning read beats are steered to the issuing master through an in-order
// tag FIFO of {port, len}, so several reads may be outstanding at once.
//
// Ports:
//   clk, rst                    controller clock, asynchronous active-high reset
//   pN_cmd / pN_cmd_en          port N command (0 read, 1 write) and request (held until ack)
//   pN_cmd_ack                  port N command accepted
//   pN_cmd_len / pN_addr        port N burst length minus 1, byte address
//   pN_wr_data / pN_wr_mask     port N write beat and byte mask
//   pN_rd_data / _valid         port N read beat (data broadcast, valid steered by tag)
//   m_*                         controller command/data interface
//   rd_orphan                   sticky: a read beat arrived with nothing outstanding
module sdramc_arb2 #(
    parameter int unsigned AW       = 23,
    parameter int unsigned DW       = 32,
    parameter int unsigned RQ_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              p0_cmd,
    input  logic              p0_cmd_en,
    output logic              p0_cmd_ack,
    input  logic [3:0]        p0_cmd_len,
    input  logic [AW-1:0]     p0_addr,
    input  logic [DW-1:0]     p0_wr_data,
    input  logic [DW/8-1:0]   p0_wr_mask,
    output logic [DW-1:0]     p0_rd_data,
    output logic              p0_rd_data_valid,

    input  logic              p1_cmd,
    input  logic              p1_cmd_en,
    output logic              p1_cmd_ack,
    input  logic [3:0]        p1_cmd_len,
    input  logic [AW-1:0]     p1_addr,
    input  logic [DW-1:0]     p1_wr_data,
    input  logic [DW/8-1:0]   p1_wr_mask,
    output logic [DW-1:0]     p1_rd_data,
    output logic              p1_rd_data_valid,

    output logic              m_cmd,
    output logic              m_cmd_en,
    input  logic              m_cmd_ack,
    output logic [3:0]        m_cmd_len,
    output logic [AW-1:0]     m_addr,
    output logic [DW-1:0]     m_wr_data,
    output logic [DW/8-1:0]   m_wr_mask,
    input  logic [DW-1:0]     m_rd_data,
    input  logic              m_rd_data_valid,

    output logic              rd_orphan
);

    localparam int unsigned PW = $clog2(RQ_DEPTH);
    localparam logic [PW:0] PtrOne = {{PW{1'b0}}, 1'b1};

    typedef enum logic [1:0] {StIdle, StReq, StWdata} state_e;

    state_e       state_q;
    logic         gnt_q;
    logic         rr_last_q;
    logic [3:0]   wcnt_q;
    logic [3:0]   rcnt_q;
    logic [PW:0]  wptr_q;
    logic [PW:0]  rptr_q;
    logic         tag_port_q [RQ_DEPTH];
    logic [3:0]   tag_len_q  [RQ_DEPTH];
    logic         orphan_q;

    logic         g_cmd;
    logic         g_cmd_en;
    logic [3:0]   g_cmd_len;
    logic         fifo_empty;
    logic         fifo_full;
    logic         elig0;
    logic         elig1;
    logic         ack_hit;
    logic         push;
    logic         beat;
    logic         pop;
    logic         head_port;
    logic [3:0]   head_len;

    // Granted-port mux; gnt resets to 0 so the m_* side follows port 0 out of reset.
    assign g_cmd     = gnt_q ? p1_cmd     : p0_cmd;
    assign g_cmd_en  = gnt_q ? p1_cmd_en  : p0_cmd_en;
    assign g_cmd_len = gnt_q ? p1_cmd_len : p0_cmd_len;

    assign m_cmd     = g_cmd;
    assign m_cmd_len = g_cmd_len;
    assign m_addr    = gnt_q ? p1_addr    : p0_addr;
    assign m_wr_data = gnt_q ? p1_wr_data : p0_wr_data;
    assign m_wr_mask = gnt_q ? p1_wr_mask : p0_wr_mask;

    // Pointers carry one extra wrap bit to tell full from empty.
    assign fifo_empty = (wptr_q == rptr_q);
    assign fifo_full  = (wptr_q[PW] != rptr_q[PW]) && (wptr_q[PW-1:0] == rptr_q[PW-1:0]);

    // A full tag FIFO only holds back reads; writes stay eligible.
    assign elig0 = p0_cmd_en && (p0_cmd || !fifo_full);
    assign elig1 = p1_cmd_en && (p1_cmd || !fifo_full);

    assign m_cmd_en   = (state_q == StReq) && g_cmd_en;
    assign ack_hit    = m_cmd_en && m_cmd_ack;
    assign p0_cmd_ack = ack_hit && !gnt_q;
    assign p1_cmd_ack = ack_hit && gnt_q;
    assign push       = ack_hit && !g_cmd;

    assign head_port = tag_port_q[rptr_q[PW-1:0]];
    assign head_len  = tag_len_q[rptr_q[PW-1:0]];
    assign beat      = m_rd_data_valid && !fifo_empty;
    assign pop       = beat && (rcnt_q == head_len);

    assign p0_rd_data       = m_rd_data;
    assign p1_rd_data       = m_rd_data;
    assign p0_rd_data_valid = beat && !head_port;
    assign p1_rd_data_valid = beat && head_port;
    assign rd_orphan        = orphan_q;

    // Grant / write-burst sequencer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            gnt_q     <= 1'b0;
            rr_last_q <= 1'b1;
            wcnt_q    <= 4'd0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (elig0 || elig1) begin
                        // Contention goes to the port that was not served last.
                        gnt_q   <= (elig0 && elig1) ? ~rr_last_q : elig1;
                        state_q <= StReq;
                    end
                end
                StReq: begin
                    if (!g_cmd_en) begin
                        state_q <= StIdle;
                    end else if (m_cmd_ack) begin
                        rr_last_q <= gnt_q;
                        // The ack cycle already carried write beat 0.
                        if (g_cmd && (g_cmd_len != 4'd0)) begin
                            wcnt_q  <= g_cmd_len;
                            state_q <= StWdata;
                        end else begin
                            state_q <= StIdle;
                        end
                    end
                end
                StWdata: begin
                    wcnt_q <= wcnt_q - 4'd1;
                    if (wcnt_q == 4'd1) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Read tag FIFO and return-beat counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q   <= '0;
            rptr_q   <= '0;
            rcnt_q   <= 4'd0;
            orphan_q <= 1'b0;
            for (int i = 0; i < int'(RQ_DEPTH); i++) begin
                tag_port_q[i] <= 1'b0;
                tag_len_q[i]  <= 4'd0;
            end
        end else begin
            if (push) begin
                tag_port_q[wptr_q[PW-1:0]] <= gnt_q;
                tag_len_q[wptr_q[PW-1:0]]  <= g_cmd_len;
                wptr_q                     <= wptr_q + PtrOne;
            end
            if (pop) begin
                rptr_q <= rptr_q + PtrOne;
                rcnt_q <= 4'd0;
            end else if (beat) begin
                rcnt_q <= rcnt_q + 4'd1;
            end
            if (m_rd_data_valid && fifo_empty) begin
                orphan_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sdramc_arb2.sv
// Self-checking bench for sdramc_arb2: directed scenarios plus a randomized run checked
// against a transaction-level model (grant rule, outstanding-read queue, beat routing).
module tb_sdramc_arb2;

    localparam int AW = 23;
    localparam int DW = 32;
    localparam int MW = DW / 8;
    localparam int RQ = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b1;

    logic            pcmd  [2];
    logic            pen   [2];
    logic [3:0]      plen  [2];
    logic [AW-1:0]   paddr [2];
    logic [DW-1:0]   pdata [2];
    logic [MW-1:0]   pmask [2];
    logic [1:0]      pack;
    logic [1:0]      prv;
    logic [DW-1:0]   prd0;
    logic [DW-1:0]   prd1;

    logic            m_cmd;
    logic            m_cmd_en;
    logic            m_cmd_ack;
    logic [3:0]      m_cmd_len;
    logic [AW-1:0]   m_addr;
    logic [DW-1:0]   m_wr_data;
    logic [MW-1:0]   m_wr_mask;
    logic [DW-1:0]   m_rd_data;
    logic            m_rd_data_valid;
    logic            rd_orphan;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    sdramc_arb2 #(.AW(AW), .DW(DW), .RQ_DEPTH(RQ)) dut (
        .clk              (clk),
        .rst              (rst),
        .p0_cmd           (pcmd[0]),
        .p0_cmd_en        (pen[0]),
        .p0_cmd_ack       (pack[0]),
        .p0_cmd_len       (plen[0]),
        .p0_addr          (paddr[0]),
        .p0_wr_data       (pdata[0]),
        .p0_wr_mask       (pmask[0]),
        .p0_rd_data       (prd0),
        .p0_rd_data_valid (prv[0]),
        .p1_cmd           (pcmd[1]),
        .p1_cmd_en        (pen[1]),
        .p1_cmd_ack       (pack[1]),
        .p1_cmd_len       (plen[1]),
        .p1_addr          (paddr[1]),
        .p1_wr_data       (pdata[1]),
        .p1_wr_mask       (pmask[1]),
        .p1_rd_data       (prd1),
        .p1_rd_data_valid (prv[1]),
        .m_cmd            (m_cmd),
        .m_cmd_en         (m_cmd_en),
        .m_cmd_ack        (m_cmd_ack),
        .m_cmd_len        (m_cmd_len),
        .m_addr           (m_addr),
        .m_wr_data        (m_wr_data),
        .m_wr_mask        (m_wr_mask),
        .m_rd_data        (m_rd_data),
        .m_rd_data_valid  (m_rd_data_valid),
        .rd_orphan        (rd_orphan)
    );

    task automatic do_reset();
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        paddr[0] = 23'h000111; paddr[1] = 23'h000222;
        plen[0] = 4'd5; plen[1] = 4'd9;
        repeat (2) @(negedge clk);
        #1;
        tests++;
        if ({m_cmd_en, pack, prv, rd_orphan} !== 6'b0) begin
            fails++;
            $display("FAIL reset_outputs: got en=%b ack=%b rv=%b orphan=%b want all 0",
                     m_cmd_en, pack, prv, rd_orphan);
        end
        tests++;
        if (m_addr !== 23'h000111 || m_cmd_len !== 4'd5) begin
            fails++;
            $display("FAIL reset_mux: got addr=%h len=%0d want addr=000111 len=5", m_addr, m_cmd_len);
        end
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic test_single_write();
        @(negedge clk);
        pcmd[0] = 1'b1; plen[0] = 4'd3; paddr[0] = 23'h000100; pdata[0] = 32'hA0;
        pmask[0] = 4'hF; pen[0] = 1'b1;
        #1;
        tests++;
        if (m_cmd_en !== 1'b0) begin
            fails++; $display("FAIL sw_no_early_en: got %b want 0", m_cmd_en);
        end
        @(negedge clk); #1;
        tests++;
        if ({m_cmd_en, m_cmd, m_cmd_len, m_addr} !== {1'b1, 1'b1, 4'd3, 23'h000100}) begin
            fails++;
            $display("FAIL sw_req: got en=%b cmd=%b len=%0d addr=%h want 1 1 3 000100",
                     m_cmd_en, m_cmd, m_cmd_len, m_addr);
        end
        m_cmd_ack = 1'b1; #1;
        tests++;
        if (pack !== 2'b01 || m_wr_data !== 32'hA0) begin
            fails++; $display("FAIL sw_beat0: got ack=%b data=%h want 01 a0", pack, m_wr_data);
        end
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            m_cmd_ack = 1'b0; pen[0] = 1'b0; pdata[0] = 32'hA0 + 32'(i);
            #1;
            tests++;
            if (m_wr_data !== 32'hA0 + 32'(i) || m_cmd_en !== 1'b0) begin
                fails++;
                $display("FAIL sw_beat%0d: got data=%h en=%b want %h 0", i, m_wr_data, m_cmd_en,
                         32'hA0 + 32'(i));
            end
        end
        // Back in IDLE now: a fresh request must be presented exactly one cycle later.
        @(negedge clk);
        plen[0] = 4'd0; paddr[0] = 23'h000104; pen[0] = 1'b1;
        @(negedge clk); #1;
        tests++;
        if (m_cmd_en !== 1'b1 || m_addr !== 23'h000104) begin
            fails++; $display("FAIL sw_idle_after: got en=%b addr=%h want 1 000104", m_cmd_en, m_addr);
        end
        m_cmd_ack = 1'b1;
        @(negedge clk); m_cmd_ack = 1'b0; pen[0] = 1'b0;
    endtask

    task automatic test_alternate();
        int g;
        do_reset();
        for (int p = 0; p < 2; p++) begin
            pcmd[p] = 1'b1; plen[p] = 4'd1; pen[p] = 1'b1;
        end
        paddr[0] = 23'h001000; paddr[1] = 23'h002000; pmask[0] = 4'h3; pmask[1] = 4'hC;
        for (int k = 0; k < 4; k++) begin
            g = k % 2;
            @(negedge clk);
            pdata[0] = $urandom; pdata[1] = $urandom; m_cmd_ack = 1'b1; #1;
            tests++;
            if (pack !== (g == 1 ? 2'b10 : 2'b01) || m_addr !== paddr[g] ||
                m_wr_data !== pdata[g] || m_wr_mask !== pmask[g]) begin
                fails++;
                $display("FAIL alt_grant%0d: got ack=%b addr=%h data=%h want port %0d addr=%h data=%h",
                         k, pack, m_addr, m_wr_data, g, paddr[g], pdata[g]);
            end
            @(negedge clk);
            m_cmd_ack = 1'b0; pdata[0] = $urandom; pdata[1] = $urandom; #1;
            tests++;
            if (m_wr_data !== pdata[g] || m_wr_mask !== pmask[g] || m_cmd_en !== 1'b0) begin
                fails++;
                $display("FAIL alt_beat%0d: got data=%h en=%b want %h 0", k, m_wr_data, m_cmd_en,
                         pdata[g]);
            end
            @(negedge clk);
            if (k == 3) begin
                pen[0] = 1'b0; pen[1] = 1'b0;
            end
        end
    endtask

    task automatic test_reads();
        logic [DW-1:0] rd;
        do_reset();
        @(negedge clk);
        pcmd[0] = 1'b0; plen[0] = 4'd1; paddr[0] = 23'h000010; pen[0] = 1'b1;
        @(negedge clk); #1;
        tests++;
        if ({m_cmd_en, m_cmd, m_cmd_len, m_addr} !== {1'b1, 1'b0, 4'd1, 23'h000010}) begin
            fails++;
            $display("FAIL rd_req0: got en=%b cmd=%b len=%0d addr=%h", m_cmd_en, m_cmd, m_cmd_len,
                     m_addr);
        end
        m_cmd_ack = 1'b1;
        @(negedge clk);
        m_cmd_ack = 1'b0; pen[0] = 1'b0;
        pcmd[1] = 1'b0; plen[1] = 4'd0; paddr[1] = 23'h000020; pen[1] = 1'b1;
        @(negedge clk); #1;
        tests++;
        if ({m_cmd_en, m_cmd, m_addr} !== {1'b1, 1'b0, 23'h000020}) begin
            fails++; $display("FAIL rd_req1: got en=%b cmd=%b addr=%h", m_cmd_en, m_cmd, m_addr);
        end
        m_cmd_ack = 1'b1;
        @(negedge clk);
        m_cmd_ack = 1'b0; pen[1] = 1'b0;
        for (int b = 0; b < 3; b++) begin
            @(negedge clk);
            rd = $urandom; m_rd_data = rd; m_rd_data_valid = 1'b1; #1;
            tests++;
            if (prv !== (b < 2 ? 2'b01 : 2'b10) || prd0 !== rd || prd1 !== rd) begin
                fails++;
                $display("FAIL rd_beat%0d: got valid=%b data=%h/%h want valid=%b data=%h", b, prv,
                         prd0, prd1, (b < 2 ? 2'b01 : 2'b10), rd);
            end
            @(negedge clk); m_rd_data_valid = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic test_orphan();
        @(negedge clk); m_rd_data_valid = 1'b1; #1;
        tests++;
        if (prv !== 2'b00) begin
            fails++; $display("FAIL orphan_no_valid: got %b want 00", prv);
        end
        @(negedge clk); m_rd_data_valid = 1'b0; #1;
        tests++;
        if (rd_orphan !== 1'b1) begin
            fails++; $display("FAIL orphan_set: got %b want 1", rd_orphan);
        end
        repeat (3) @(negedge clk);
        tests++;
        if (rd_orphan !== 1'b1) begin
            fails++; $display("FAIL orphan_sticky: got %b want 1", rd_orphan);
        end
        rst = 1'b1; #1;
        tests++;
        if (rd_orphan !== 1'b0) begin
            fails++; $display("FAIL orphan_clear: got %b want 0", rd_orphan);
        end
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic test_fifo_full();
        for (int i = 0; i < RQ; i++) begin
            @(negedge clk);
            pcmd[0] = 1'b0; plen[0] = 4'd0; paddr[0] = 23'h000040 + 23'(i * 4); pen[0] = 1'b1;
            @(negedge clk); #1;
            tests++;
            if (m_cmd_en !== 1'b1 || m_addr !== paddr[0]) begin
                fails++; $display("FAIL full_fill%0d: got en=%b addr=%h", i, m_cmd_en, m_addr);
            end
            m_cmd_ack = 1'b1;
            @(negedge clk); m_cmd_ack = 1'b0; pen[0] = 1'b0;
        end
        @(negedge clk);
        paddr[0] = 23'h000050; pen[0] = 1'b1;
        @(negedge clk); #1;
        tests++;
        if (m_cmd_en !== 1'b0) begin
            fails++; $display("FAIL full_block: got en=%b want 0", m_cmd_en);
        end
        pcmd[1] = 1'b1; plen[1] = 4'd0; paddr[1] = 23'h000300; pdata[1] = $urandom; pen[1] = 1'b1;
        @(negedge clk); #1;
        tests++;
        if ({m_cmd_en, m_cmd, m_addr} !== {1'b1, 1'b1, 23'h000300}) begin
            fails++; $display("FAIL full_write: got en=%b cmd=%b addr=%h", m_cmd_en, m_cmd, m_addr);
        end
        m_cmd_ack = 1'b1; #1;
        tests++;
        if (pack !== 2'b10) begin
            fails++; $display("FAIL full_write_ack: got %b want 10", pack);
        end
        @(negedge clk);
        m_cmd_ack = 1'b0; pen[1] = 1'b0; m_rd_data = $urandom; m_rd_data_valid = 1'b1; #1;
        tests++;
        if (m_cmd_en !== 1'b0 || prv !== 2'b01) begin
            fails++; $display("FAIL full_return: got en=%b valid=%b want 0 01", m_cmd_en, prv);
        end
        @(negedge clk); m_rd_data_valid = 1'b0;
        @(negedge clk); #1;
        tests++;
        if ({m_cmd_en, m_cmd, m_addr} !== {1'b1, 1'b0, 23'h000050}) begin
            fails++; $display("FAIL full_unblock: got en=%b cmd=%b addr=%h", m_cmd_en, m_cmd, m_addr);
        end
        m_cmd_ack = 1'b1;
        @(negedge clk); m_cmd_ack = 1'b0; pen[0] = 1'b0;
        for (int i = 0; i < RQ; i++) begin
            @(negedge clk); m_rd_data_valid = 1'b1; #1;
            tests++;
            if (prv !== 2'b01) begin
                fails++; $display("FAIL full_drain%0d: got %b want 01", i, prv);
            end
            @(negedge clk); m_rd_data_valid = 1'b0;
        end
    endtask

    task automatic test_reset_burst();
        @(negedge clk);
        paddr[0] = 23'h000123; plen[0] = 4'd7;
        pcmd[1] = 1'b1; plen[1] = 4'd3; paddr[1] = 23'h000400; pen[1] = 1'b1;
        @(negedge clk); m_cmd_ack = 1'b1;
        @(negedge clk); m_cmd_ack = 1'b0; pen[1] = 1'b0;
        @(negedge clk);
        rst = 1'b1; #1;
        tests++;
        if ({m_cmd_en, pack, prv, rd_orphan} !== 6'b0 || m_addr !== 23'h000123 ||
            m_cmd_len !== 4'd7) begin
            fails++;
            $display("FAIL rst_burst_outputs: got en=%b ack=%b addr=%h len=%0d want 0 00 000123 7",
                     m_cmd_en, pack, m_addr, m_cmd_len);
        end
        @(negedge clk);
        rst = 1'b0;
        pcmd[0] = 1'b1; plen[0] = 4'd0; pcmd[1] = 1'b1; plen[1] = 4'd0;
        pen[0] = 1'b1; pen[1] = 1'b1;
        @(negedge clk); #1;
        tests++;
        if (m_cmd_en !== 1'b1 || m_addr !== 23'h000123) begin
            fails++;
            $display("FAIL rst_burst_regrant: got en=%b addr=%h want 1 000123", m_cmd_en, m_addr);
        end
        m_cmd_ack = 1'b1; #1;
        tests++;
        if (pack !== 2'b01) begin
            fails++; $display("FAIL rst_burst_ack: got %b want 01", pack);
        end
        @(negedge clk); m_cmd_ack = 1'b0; pen[0] = 1'b0; pen[1] = 1'b0;
    endtask

    task automatic test_random();
        int            q_port[$];
        int            q_len[$];
        int            rcnt;
        int            last;
        int            g;
        int            nb;
        bit            pend [2];
        bit            elig [2];
        logic [1:0]    ev;
        logic [DW-1:0] rd;
        do_reset();
        last = 1; rcnt = 0; pend[0] = 1'b0; pend[1] = 1'b0;
        for (int it = 0; it < 250; it++) begin
            nb = (it == 249) ? 64 : $urandom_range(0, 3);
            for (int b = 0; b < nb && q_port.size() > 0; b++) begin
                if ($urandom_range(0, 1) == 1) begin
                    @(negedge clk); m_rd_data_valid = 1'b0;
                end
                @(negedge clk);
                rd = $urandom; m_rd_data = rd; m_rd_data_valid = 1'b1; #1;
                ev = (q_port[0] == 1) ? 2'b10 : 2'b01;
                tests++;
                if (prv !== ev || prd0 !== rd || prd1 !== rd) begin
                    fails++;
                    $display("FAIL rnd_beat it%0d: got valid=%b data=%h want valid=%b data=%h", it,
                             prv, prd0, ev, rd);
                end
                rcnt++;
                if (rcnt > q_len[0]) begin
                    void'(q_port.pop_front()); void'(q_len.pop_front()); rcnt = 0;
                end
            end
            @(negedge clk); m_rd_data_valid = 1'b0;
            if (it == 249) break;
            for (int p = 0; p < 2; p++) begin
                if (!pend[p] && $urandom_range(0, 2) != 0) begin
                    pend[p] = 1'b1; pcmd[p] = 1'($urandom_range(0, 1));
                    plen[p] = 4'($urandom_range(0, 3)); paddr[p] = 23'($urandom);
                    pmask[p] = 4'($urandom);
                end
                elig[p] = pend[p] && (pcmd[p] || q_port.size() < RQ);
            end
            if (!pend[0] && !pend[1]) continue;
            pen[0] = pend[0]; pen[1] = pend[1];
            @(negedge clk);
            if (!elig[0] && !elig[1]) begin
                #1;
                tests++;
                if (m_cmd_en !== 1'b0) begin
                    fails++; $display("FAIL rnd_blocked it%0d: got en=%b want 0", it, m_cmd_en);
                end
                pen[0] = 1'b0; pen[1] = 1'b0;
                continue;
            end
            g = (elig[0] && elig[1]) ? 1 - last : (elig[0] ? 0 : 1);
            pdata[0] = $urandom; pdata[1] = $urandom; m_cmd_ack = 1'b1; #1;
            tests++;
            if ({m_cmd_en, m_cmd, m_cmd_len, m_addr} !== {1'b1, pcmd[g], plen[g], paddr[g]} ||
                pack !== (g == 1 ? 2'b10 : 2'b01) ||
                (pcmd[g] && (m_wr_data !== pdata[g] || m_wr_mask !== pmask[g]))) begin
                fails++;
                $display("FAIL rnd_grant it%0d: got en=%b addr=%h ack=%b data=%h want port %0d addr=%h",
                         it, m_cmd_en, m_addr, pack, m_wr_data, g, paddr[g]);
            end
            last = g; pend[g] = 1'b0;
            if (!pcmd[g]) begin
                q_port.push_back(g); q_len.push_back(int'(plen[g]));
            end
            @(negedge clk);
            m_cmd_ack = 1'b0; pen[0] = 1'b0; pen[1] = 1'b0;
            if (pcmd[g]) begin
                for (int b = 1; b <= int'(plen[g]); b++) begin
                    if (b > 1) @(negedge clk);
                    pdata[0] = $urandom; pdata[1] = $urandom; #1;
                    tests++;
                    if (m_wr_data !== pdata[g] || m_wr_mask !== pmask[g] || m_cmd_en !== 1'b0) begin
                        fails++;
                        $display("FAIL rnd_wbeat it%0d b%0d: got data=%h en=%b want %h 0", it, b,
                                 m_wr_data, m_cmd_en, pdata[g]);
                    end
                end
            end
        end
        tests++;
        if (q_port.size() != 0 || rd_orphan !== 1'b0) begin
            fails++;
            $display("FAIL rnd_drain: got left=%0d orphan=%b want 0 0", q_port.size(), rd_orphan);
        end
        // Model says nothing is outstanding, so one more beat must be an orphan.
        @(negedge clk); m_rd_data_valid = 1'b1; #1;
        tests++;
        if (prv !== 2'b00) begin
            fails++; $display("FAIL rnd_empty: got valid=%b want 00", prv);
        end
        @(negedge clk); m_rd_data_valid = 1'b0; #1;
        tests++;
        if (rd_orphan !== 1'b1) begin
            fails++; $display("FAIL rnd_orphan: got %b want 1", rd_orphan);
        end
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            pcmd[i] = 1'b0; pen[i] = 1'b0; plen[i] = 4'd0; paddr[i] = '0;
            pdata[i] = '0; pmask[i] = '0;
        end
        m_cmd_ack = 1'b0; m_rd_data = '0; m_rd_data_valid = 1'b0;
        test_reset();
        test_single_write();
        test_alternate();
        test_reads();
        test_orphan();
        test_fifo_full();
        test_reset_burst();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

endmodule
